// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_unit
//  Purpose  : Instruction-fetch stage in front of a 16-bit instruction
//             memory. It owns the program counter, drives the memory read
//             enable and word address, and captures the returned word into
//             an instruction register for the decoder. It handles stalls,
//             branch/jump redirects (one squash bubble) and a halt opcode.
//             Fetch is a 2-stage pipeline: PC -> IR. Memory read data is
//             combinational from imem_addr_o.
//  Ports    :
//    clk              clock, all state updates on the rising edge
//    rst              synchronous active-high reset
//    stall_i          downstream hold request
//    branch_taken_i   branch redirect for the instruction held in IR
//    branch_offset_i  signed word offset, relative to instr_pc_o + 1
//    jump_i           absolute-jump redirect for the instruction held in IR
//    jump_target_i    absolute word address for the jump
//    imem_read_o      memory read enable (high only while running)
//    imem_addr_o      memory word address (pc masked to the memory depth)
//    imem_data_i      memory read data
//    instr_o          instruction register
//    instr_pc_o       address the word in instr_o was fetched from
//    instr_valid_o    instr_o holds a live instruction
//    halted_o         fetch stopped (halt opcode, or out-of-range trap)
//    fetch_count_o    valid instructions delivered, saturating at 16'hFFFF
//    fetch_fault_o    out-of-range fetch trap (FETCH_OOB_TRAP_EN only)
//  Options  : `define FETCH_OOB_TRAP_EN adds fetch_fault_o; a fetch from
//             pc >= IMEM_DEPTH then halts instead of wrapping via the mask.
//  Revision : 1.0  initial release
// ============================================================================
module fetch_unit #(
  parameter logic [15:0] RESET_PC    = 16'h0000,
  parameter int unsigned IMEM_DEPTH  = 256,
  parameter logic [3:0]  HALT_OPCODE = 4'hF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_i,
  input  logic        branch_taken_i,
  input  logic [7:0]  branch_offset_i,
  input  logic        jump_i,
  input  logic [15:0] jump_target_i,
  output logic        imem_read_o,
  output logic [15:0] imem_addr_o,
  input  logic [15:0] imem_data_i,
  output logic [15:0] instr_o,
  output logic [15:0] instr_pc_o,
  output logic        instr_valid_o,
  output logic        halted_o,
  output logic [15:0] fetch_count_o
`ifdef FETCH_OOB_TRAP_EN
  ,
  output logic        fetch_fault_o
`endif
);

  localparam logic [1:0]  c_ST_BOOT   = 2'd0;
  localparam logic [1:0]  c_ST_RUN    = 2'd1;
  localparam logic [1:0]  c_ST_HALT   = 2'd2;
  localparam logic [15:0] c_ADDR_MASK = 16'(IMEM_DEPTH - 1);

  logic [1:0]  state_q,       state_d;
  logic [15:0] pc_q,          pc_d;
  logic [15:0] instr_q,       instr_d;
  logic [15:0] instr_pc_q,    instr_pc_d;
  logic        instr_valid_q, instr_valid_d;
  logic [15:0] fetch_count_q, fetch_count_d;
`ifdef FETCH_OOB_TRAP_EN
  logic        fault_q,       fault_d;
`endif

  logic [15:0] w_branch_pc;
  logic        w_halt_det;
  logic        w_oob;

  // Branch offsets are relative to the instruction after the one in IR.
  assign w_branch_pc = instr_pc_q + 16'd1 + {{8{branch_offset_i[7]}}, branch_offset_i};
  assign w_halt_det  = instr_valid_q && (instr_q[15:12] == HALT_OPCODE);

`ifdef FETCH_OOB_TRAP_EN
  assign w_oob = ({16'h0000, pc_q} >= IMEM_DEPTH);
`else
  assign w_oob = 1'b0;
`endif

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= c_ST_BOOT;
      pc_q          <= RESET_PC;
      instr_q       <= 16'h0000;
      instr_pc_q    <= 16'h0000;
      instr_valid_q <= 1'b0;
      fetch_count_q <= 16'h0000;
`ifdef FETCH_OOB_TRAP_EN
      fault_q       <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      instr_q       <= instr_d;
      instr_pc_q    <= instr_pc_d;
      instr_valid_q <= instr_valid_d;
      fetch_count_q <= fetch_count_d;
`ifdef FETCH_OOB_TRAP_EN
      fault_q       <= fault_d;
`endif
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    instr_d       = instr_q;
    instr_pc_d    = instr_pc_q;
    instr_valid_d = instr_valid_q;
    fetch_count_d = fetch_count_q;
`ifdef FETCH_OOB_TRAP_EN
    fault_d       = fault_q;
`endif

    case (state_q)
      c_ST_BOOT: begin
        state_d = c_ST_RUN;
      end

      c_ST_RUN: begin
        // Redirects and halt only act on a live IR word; with IR empty they
        // fall through to the stall / sequential-fetch cases.
        if (instr_valid_q && jump_i) begin
          pc_d          = jump_target_i;
          instr_valid_d = 1'b0;
        end else if (instr_valid_q && branch_taken_i) begin
          pc_d          = w_branch_pc;
          instr_valid_d = 1'b0;
        end else if (w_halt_det) begin
          state_d       = c_ST_HALT;
          instr_valid_d = 1'b0;
        end else if (stall_i) begin
          // hold everything
        end else if (w_oob) begin
          state_d       = c_ST_HALT;
          instr_valid_d = 1'b0;
`ifdef FETCH_OOB_TRAP_EN
          fault_d       = 1'b1;
`endif
        end else begin
          instr_d       = imem_data_i;
          instr_pc_d    = pc_q;
          instr_valid_d = 1'b1;
          pc_d          = pc_q + 16'd1;
          if (fetch_count_q != 16'hFFFF) begin
            fetch_count_d = fetch_count_q + 16'd1;
          end
        end
      end

      c_ST_HALT: begin
        // frozen until reset
      end

      default: begin
        state_d = c_ST_BOOT;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  always_comb begin
    imem_read_o   = (state_q == c_ST_RUN);
    halted_o      = (state_q == c_ST_HALT);
    imem_addr_o   = pc_q & c_ADDR_MASK;
    instr_o       = instr_q;
    instr_pc_o    = instr_pc_q;
    instr_valid_o = instr_valid_q;
    fetch_count_o = fetch_count_q;
`ifdef FETCH_OOB_TRAP_EN
    fetch_fault_o = fault_q;
`endif
  end

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fetch_unit
//  Purpose  : Directed self-checking bench for fetch_unit with a 256-word
//             combinational instruction memory model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall_i;
  logic        branch_taken_i;
  logic [7:0]  branch_offset_i;
  logic        jump_i;
  logic [15:0] jump_target_i;
  logic        imem_read_o;
  logic [15:0] imem_addr_o;
  logic [15:0] imem_data_i;
  logic [15:0] instr_o;
  logic [15:0] instr_pc_o;
  logic        instr_valid_o;
  logic        halted_o;
  logic [15:0] fetch_count_o;
`ifdef FETCH_OOB_TRAP_EN
  logic        fetch_fault_o;
`endif

  logic [15:0] mem [0:255];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign imem_data_i = mem[imem_addr_o[7:0]];

  fetch_unit #(
    .RESET_PC    (16'h0000),
    .IMEM_DEPTH  (256),
    .HALT_OPCODE (4'hF)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .stall_i         (stall_i),
    .branch_taken_i  (branch_taken_i),
    .branch_offset_i (branch_offset_i),
    .jump_i          (jump_i),
    .jump_target_i   (jump_target_i),
    .imem_read_o     (imem_read_o),
    .imem_addr_o     (imem_addr_o),
    .imem_data_i     (imem_data_i),
    .instr_o         (instr_o),
    .instr_pc_o      (instr_pc_o),
    .instr_valid_o   (instr_valid_o),
    .halted_o        (halted_o),
    .fetch_count_o   (fetch_count_o)
`ifdef FETCH_OOB_TRAP_EN
    ,
    .fetch_fault_o   (fetch_fault_o)
`endif
  );

  // Advance one edge and sample 1 time unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int cycles);
    rst = 1'b1;
    for (int i = 0; i < cycles; i++) tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset(2);
    checks++; if (imem_read_o !== 1'b0) begin errors++; $display("FAIL reset_read got %b exp 0", imem_read_o); end
    checks++; if (instr_valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", instr_valid_o); end
    checks++; if (instr_o !== 16'h0000 || instr_pc_o !== 16'h0000) begin errors++; $display("FAIL reset_ir got %h/%h exp 0000/0000", instr_o, instr_pc_o); end
    checks++; if (halted_o !== 1'b0 || fetch_count_o !== 16'h0000) begin errors++; $display("FAIL reset_halt_cnt got %b/%h exp 0/0000", halted_o, fetch_count_o); end
    tick(); // BOOT -> RUN
    checks++; if (imem_read_o !== 1'b1 || imem_addr_o !== 16'h0000 || instr_valid_o !== 1'b0) begin errors++; $display("FAIL boot_exit got rd=%b addr=%h v=%b exp 1/0000/0", imem_read_o, imem_addr_o, instr_valid_o); end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (instr_o !== 16'h1000 + 16'(i) || instr_pc_o !== 16'(i) || instr_valid_o !== 1'b1) begin errors++; $display("FAIL seq_fetch%0d got %h@%h v=%b exp %h@%h v=1", i, instr_o, instr_pc_o, instr_valid_o, 16'h1000 + 16'(i), 16'(i)); end
    end
    checks++; if (fetch_count_o !== 16'd3) begin errors++; $display("FAIL seq_count got %0d exp 3", fetch_count_o); end
  endtask

  task automatic test_stall();
    stall_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (instr_o !== 16'h1002 || instr_pc_o !== 16'h0002 || imem_addr_o !== 16'h0003 || fetch_count_o !== 16'd3) begin errors++; $display("FAIL stall_hold%0d got %h@%h addr=%h cnt=%0d exp 1002@0002 addr=0003 cnt=3", i, instr_o, instr_pc_o, imem_addr_o, fetch_count_o); end
    end
    stall_i = 1'b0;
    tick();
    checks++; if (instr_o !== 16'h1003 || instr_pc_o !== 16'h0003 || fetch_count_o !== 16'd4) begin errors++; $display("FAIL stall_resume got %h@%h cnt=%0d exp 1003@0003 cnt=4", instr_o, instr_pc_o, fetch_count_o); end
  endtask

  task automatic test_branch();
    tick(); tick(); // instr_pc 4, then 5
    checks++; if (instr_pc_o !== 16'h0005) begin errors++; $display("FAIL br_setup got %h exp 0005", instr_pc_o); end
    branch_taken_i = 1'b1; branch_offset_i = 8'hFC;
    tick();
    branch_taken_i = 1'b0;
    checks++; if (instr_valid_o !== 1'b0 || imem_addr_o !== 16'h0002) begin errors++; $display("FAIL br_bubble got v=%b addr=%h exp v=0 addr=0002", instr_valid_o, imem_addr_o); end
    tick();
    checks++; if (instr_o !== 16'h1002 || instr_pc_o !== 16'h0002 || instr_valid_o !== 1'b1 || fetch_count_o !== 16'd7) begin errors++; $display("FAIL br_target got %h@%h v=%b cnt=%0d exp 1002@0002 v=1 cnt=7", instr_o, instr_pc_o, instr_valid_o, fetch_count_o); end
    // jump and branch together: jump wins
    jump_i = 1'b1; jump_target_i = 16'h0040; branch_taken_i = 1'b1; branch_offset_i = 8'hFC;
    tick();
    jump_i = 1'b0;
    // branch still high during the bubble: must be ignored (IR empty)
    branch_offset_i = 8'h10;
    checks++; if (instr_valid_o !== 1'b0 || imem_addr_o !== 16'h0040) begin errors++; $display("FAIL jmp_prio got v=%b addr=%h exp v=0 addr=0040", instr_valid_o, imem_addr_o); end
    tick();
    branch_taken_i = 1'b0;
    checks++; if (instr_o !== 16'h1040 || instr_pc_o !== 16'h0040 || fetch_count_o !== 16'd8) begin errors++; $display("FAIL jmp_target got %h@%h cnt=%0d exp 1040@0040 cnt=8", instr_o, instr_pc_o, fetch_count_o); end
    // redirect honoured while stalled
    stall_i = 1'b1; jump_i = 1'b1; jump_target_i = 16'h0010;
    tick();
    jump_i = 1'b0;
    tick();
    checks++; if (instr_valid_o !== 1'b0 || imem_addr_o !== 16'h0010) begin errors++; $display("FAIL jmp_stall got v=%b addr=%h exp v=0 addr=0010", instr_valid_o, imem_addr_o); end
    stall_i = 1'b0;
    tick();
    checks++; if (instr_o !== 16'h1010 || instr_pc_o !== 16'h0010 || fetch_count_o !== 16'd9) begin errors++; $display("FAIL jmp_stall_fetch got %h@%h cnt=%0d exp 1010@0010 cnt=9", instr_o, instr_pc_o, fetch_count_o); end
  endtask

  task automatic test_wrap_oob();
`ifndef FETCH_OOB_TRAP_EN
    jump_i = 1'b1; jump_target_i = 16'hFFFF;
    tick();
    jump_i = 1'b0;
    checks++; if (imem_addr_o !== 16'h00FF) begin errors++; $display("FAIL wrap_addr got %h exp 00FF", imem_addr_o); end
    tick();
    checks++; if (instr_o !== 16'h10FF || instr_pc_o !== 16'hFFFF || imem_addr_o !== 16'h0000) begin errors++; $display("FAIL wrap_pc got %h@%h addr=%h exp 10FF@FFFF addr=0000", instr_o, instr_pc_o, imem_addr_o); end
    tick();
    checks++; if (instr_o !== 16'h1000 || instr_pc_o !== 16'h0000 || fetch_count_o !== 16'd11) begin errors++; $display("FAIL wrap_next got %h@%h cnt=%0d exp 1000@0000 cnt=11", instr_o, instr_pc_o, fetch_count_o); end
    jump_i = 1'b1; jump_target_i = 16'h0100;
    tick();
    jump_i = 1'b0;
    checks++; if (imem_addr_o !== 16'h0000) begin errors++; $display("FAIL oob_mask got %h exp 0000", imem_addr_o); end
    tick();
    checks++; if (instr_o !== 16'h1000 || instr_pc_o !== 16'h0100 || instr_valid_o !== 1'b1 || halted_o !== 1'b0) begin errors++; $display("FAIL oob_wrap got %h@%h v=%b h=%b exp 1000@0100 v=1 h=0", instr_o, instr_pc_o, instr_valid_o, halted_o); end
`else
    jump_i = 1'b1; jump_target_i = 16'h0100;
    tick();
    jump_i = 1'b0;
    checks++; if (fetch_fault_o !== 1'b0 || halted_o !== 1'b0) begin errors++; $display("FAIL oob_pre got f=%b h=%b exp 0/0", fetch_fault_o, halted_o); end
    tick();
    checks++; if (fetch_fault_o !== 1'b1 || halted_o !== 1'b1 || instr_valid_o !== 1'b0 || imem_read_o !== 1'b0) begin errors++; $display("FAIL oob_trap got f=%b h=%b v=%b rd=%b exp 1/1/0/0", fetch_fault_o, halted_o, instr_valid_o, imem_read_o); end
    do_reset(1);
    checks++; if (fetch_fault_o !== 1'b0 || halted_o !== 1'b0) begin errors++; $display("FAIL oob_clear got f=%b h=%b exp 0/0", fetch_fault_o, halted_o); end
`endif
  endtask

  task automatic test_halt();
    mem[3] = 16'hF000;
    do_reset(2);
    tick(); // BOOT -> RUN
    for (int i = 0; i < 4; i++) tick();
    checks++; if (instr_o !== 16'hF000 || instr_valid_o !== 1'b1 || halted_o !== 1'b0) begin errors++; $display("FAIL halt_fetch got %h v=%b h=%b exp F000 v=1 h=0", instr_o, instr_valid_o, halted_o); end
    tick();
    checks++; if (halted_o !== 1'b1 || instr_valid_o !== 1'b0 || imem_read_o !== 1'b0) begin errors++; $display("FAIL halt_enter got h=%b v=%b rd=%b exp 1/0/0", halted_o, instr_valid_o, imem_read_o); end
    jump_i = 1'b1; jump_target_i = 16'h0020;
    for (int i = 0; i < 10; i++) tick();
    jump_i = 1'b0;
    checks++; if (halted_o !== 1'b1 || instr_o !== 16'hF000 || instr_pc_o !== 16'h0003 || imem_addr_o !== 16'h0004 || fetch_count_o !== 16'd4) begin errors++; $display("FAIL halt_hold got h=%b %h@%h addr=%h cnt=%0d exp 1 F000@0003 addr=0004 cnt=4", halted_o, instr_o, instr_pc_o, imem_addr_o, fetch_count_o); end
    do_reset(1);
    checks++; if (halted_o !== 1'b0 || imem_read_o !== 1'b0 || instr_o !== 16'h0000 || fetch_count_o !== 16'd0) begin errors++; $display("FAIL halt_reset got h=%b rd=%b ir=%h cnt=%0d exp 0/0/0000/0", halted_o, imem_read_o, instr_o, fetch_count_o); end
    mem[3] = 16'h1003;
  endtask

  task automatic test_saturate();
`ifndef FETCH_OOB_TRAP_EN
    int n;
    do_reset(1);
    n = 0;
    while (fetch_count_o !== 16'hFFFE && n < 70000) begin
      tick();
      n++;
    end
    checks++; if (fetch_count_o !== 16'hFFFE) begin errors++; $display("FAIL sat_reach got %h exp FFFE (timeout)", fetch_count_o); end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (fetch_count_o !== 16'hFFFF || instr_valid_o !== 1'b1) begin errors++; $display("FAIL sat_hold%0d got %h v=%b exp FFFF v=1", i, fetch_count_o, instr_valid_o); end
    end
`endif
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'h1000 + 16'(i);
    rst = 1'b1; stall_i = 1'b0; branch_taken_i = 1'b0; branch_offset_i = 8'h00;
    jump_i = 1'b0; jump_target_i = 16'h0000;
    test_reset();
    test_stall();
    test_branch();
    test_wrap_oob();
    test_halt();
    test_saturate();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
